// File: rtl/adc_fft_frame_sched_pkg.sv
// Shared constants for the ADC->FFT frame scheduler: FSM encodings and FIFO read latency.
package adc_fft_frame_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Data from the upstream FIFO lands this many cycles after fifo_r_en.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/adc_fft_skid2.sv
// Two-entry register skid FIFO. Entry 0 is the head; a simultaneous write and read keeps order.
module adc_fft_skid2 #(
  parameter int W = 12
) (
  input  logic         rclk,
  input  logic         rrst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0, ent1;
  logic         rd_ok;

  assign rd_ok   = rd_en & (occ != 2'd0);
  assign rd_data = ent0;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({wr_en, rd_ok})
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= wr_data;
          end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end
        end
        2'b10: begin
          if (occ == 2'd0) ent0 <= wr_data;
          else             ent1 <= wr_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_fft_frame_sched.sv
// Read-side frame scheduler: waits for a full frame in the ADC FIFO, then bursts it to the FFT
// as a sop/last-marked valid/ready stream through a 2-entry skid buffer.
module adc_fft_frame_sched
  import adc_fft_frame_sched_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int LVL_W     = 10,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 9
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              cfg_mode,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              fifo_rempty,
  input  logic [LVL_W-1:0]  fifo_rd_level,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tsop,
  output logic              m_tlast,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              stall_err
);

  localparam logic [CNT_W-1:0] FL     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FL_M1  = CNT_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0] FL_LVL = LVL_W'(FRAME_LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] iss_cnt, out_cnt;
  logic             inflight, stop_pend;
  logic [1:0]       skid_occ;
  logic [2:0]       occ_eff;
  logic             hs, last_hs, iss_open, stop_now;

  adc_fft_skid2 #(.W(DATA_W)) u_skid (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .wr_en   (inflight),
    .wr_data (fifo_rdata),
    .rd_en   (hs),
    .rd_data (m_tdata),
    .occ     (skid_occ)
  );

  assign m_tvalid = (skid_occ != 2'd0);
  assign hs       = m_tvalid & m_tready;
  assign last_hs  = hs & (out_cnt == FL_M1);
  assign m_tsop   = m_tvalid & (out_cnt == '0);
  assign m_tlast  = m_tvalid & (out_cnt == FL_M1);
  assign busy     = (state != ST_IDLE);
  assign iss_open = (iss_cnt < FL);
  assign stop_now = stop_pend | cfg_stop;

  // Credit counts the beat leaving this cycle so a steady ready stream keeps one read per cycle;
  // the skid buffer still never holds more than two entries.
  assign occ_eff   = {1'b0, skid_occ} + {2'b0, inflight} - {2'b0, hs};
  assign fifo_r_en = (state == ST_BURST) & !fifo_rempty & iss_open & (occ_eff < 3'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= ST_IDLE;
      iss_cnt   <= '0;
      out_cnt   <= '0;
      inflight  <= 1'b0;
      stop_pend <= 1'b0;
      frame_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      if (hs) out_cnt <= out_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (cfg_start && !cfg_stop) begin
            state     <= ST_WAIT;
            frame_cnt <= '0;
            stall_err <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cfg_stop) begin
            state <= ST_IDLE;
          end else if (fifo_rd_level >= FL_LVL && !fifo_rempty) begin
            state   <= ST_BURST;
            iss_cnt <= '0;
            out_cnt <= '0;
          end
        end
        ST_BURST: begin
          if (cfg_stop) stop_pend <= 1'b1;
          if (fifo_rempty && iss_open) stall_err <= 1'b1;
          if (fifo_r_en) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == FL_M1) state <= ST_FLUSH;
          end
        end
        default: begin
          if (cfg_stop) stop_pend <= 1'b1;
          if (last_hs) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (cfg_mode && !stop_now) begin
              state <= ST_WAIT;
            end else begin
              state     <= ST_IDLE;
              stop_pend <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
